// File: rtl/dram_contention_arbiter.sv
// Round-robin arbiter for the shared DRAM request port, with an optional
// per-requester token bucket that throttles requesters to model memory contention.
module dram_contention_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ADDR_W   = 32,
  parameter int TOKEN_W  = 8,
  parameter int REFILL_W = 16,
  localparam int SRC_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cfg_enable,
  input  logic [TOKEN_W-1:0]        cfg_tokens_max,
  input  logic [REFILL_W-1:0]       cfg_refill_period,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      mem_valid,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [SRC_W-1:0]          mem_src,
  input  logic                      mem_ready,
  output logic                      busy,
  output logic [31:0]               throttle_cycles
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  localparam logic [NUM_REQ-1:0]  ONE_HOT0   = {{(NUM_REQ-1){1'b0}}, 1'b1};
  localparam logic [REFILL_W-1:0] REFILL_ONE = {{(REFILL_W-1){1'b0}}, 1'b1};

  state_e              state_r;
  logic [SRC_W-1:0]    rr_r;
  logic [TOKEN_W-1:0]  tokens_r     [NUM_REQ];
  logic [TOKEN_W-1:0]  tokens_nxt_s [NUM_REQ];
  logic [ADDR_W-1:0]   addr_arr_s   [NUM_REQ];
  logic [REFILL_W-1:0] refill_cnt_r;
  logic                enable_q_r;
  logic [NUM_REQ-1:0]  eligible_s;
  logic [NUM_REQ-1:0]  consume_s;
  logic [SRC_W-1:0]    winner_s;
  logic [SRC_W-1:0]    scan_idx_s;
  logic                grant_s;
  logic                throttle_s;
  logic                enable_rise_s;
  logic                refill_pulse_s;

  // Refilled bucket level: +1 token minus an optional same-cycle consume, capped.
  function automatic logic [TOKEN_W-1:0] refill_level(
    input logic [TOKEN_W-1:0] level,
    input logic [TOKEN_W-1:0] cap,
    input logic               take
  );
    logic [TOKEN_W:0] sum;
    sum = {1'b0, level} + {{TOKEN_W{1'b0}}, 1'b1} - {{TOKEN_W{1'b0}}, take};
    refill_level = (sum > {1'b0, cap}) ? cap : sum[TOKEN_W-1:0];
  endfunction

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    assign addr_arr_s[g] = req_addr[g*ADDR_W +: ADDR_W];
    assign eligible_s[g] = req_valid[g] && (!cfg_enable || (tokens_r[g] != {TOKEN_W{1'b0}}));
  end

  // Round-robin pick: scanning from the far end lets the nearest eligible index after rr win.
  always_comb begin
    winner_s   = rr_r;
    scan_idx_s = rr_r;
    for (int k = NUM_REQ; k >= 1; k--) begin
      scan_idx_s = SRC_W'((int'(rr_r) + k) % NUM_REQ);
      winner_s   = eligible_s[scan_idx_s] ? scan_idx_s : winner_s;
    end
    grant_s        = !reset && (state_r == ST_IDLE) && (|eligible_s);
    req_ready      = grant_s ? (ONE_HOT0 << winner_s) : {NUM_REQ{1'b0}};
    consume_s      = cfg_enable ? req_ready : {NUM_REQ{1'b0}};
    throttle_s     = (state_r == ST_IDLE) && cfg_enable && (|req_valid) && !(|eligible_s);
    enable_rise_s  = cfg_enable && !enable_q_r;
    refill_pulse_s = (cfg_refill_period <= REFILL_ONE) ||
                     (refill_cnt_r >= (cfg_refill_period - REFILL_ONE));
  end

  // Next bucket levels; an enable rising edge reloads and overrides refill/consume.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (enable_rise_s) begin
        tokens_nxt_s[i] = cfg_tokens_max;
      end else if (!cfg_enable) begin
        tokens_nxt_s[i] = tokens_r[i];
      end else if (refill_pulse_s) begin
        tokens_nxt_s[i] = refill_level(tokens_r[i], cfg_tokens_max, consume_s[i]);
      end else begin
        tokens_nxt_s[i] = tokens_r[i] - {{(TOKEN_W-1){1'b0}}, consume_s[i]};
      end
    end
  end

  // Token buckets, refill timer and enable edge tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        tokens_r[i] <= {TOKEN_W{1'b0}};
      end
      refill_cnt_r <= {REFILL_W{1'b0}};
      enable_q_r   <= 1'b0;
    end else begin
      enable_q_r <= cfg_enable;
      for (int i = 0; i < NUM_REQ; i++) begin
        tokens_r[i] <= tokens_nxt_s[i];
      end
      if (enable_rise_s || (cfg_enable && refill_pulse_s)) begin
        refill_cnt_r <= {REFILL_W{1'b0}};
      end else if (cfg_enable) begin
        refill_cnt_r <= refill_cnt_r + REFILL_ONE;
      end else begin
        refill_cnt_r <= refill_cnt_r;
      end
    end
  end

  // Grant FSM with registered memory-side outputs and the throttle statistic.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r         <= ST_IDLE;
      mem_valid       <= 1'b0;
      mem_addr        <= {ADDR_W{1'b0}};
      mem_src         <= {SRC_W{1'b0}};
      busy            <= 1'b0;
      rr_r            <= {SRC_W{1'b0}};
      throttle_cycles <= 32'd0;
    end else begin
      if (throttle_s && (throttle_cycles != 32'hFFFF_FFFF)) begin
        throttle_cycles <= throttle_cycles + 32'd1;
      end
      case (state_r)
        ST_IDLE: begin
          if (grant_s) begin
            mem_addr  <= addr_arr_s[winner_s];
            mem_src   <= winner_s;
            mem_valid <= 1'b1;
            busy      <= 1'b1;
            rr_r      <= winner_s;
            state_r   <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            busy      <= 1'b0;
            state_r   <= ST_IDLE;
          end
        end
        default: begin
          mem_valid <= 1'b0;
          busy      <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dram_contention_arbiter.sv
// Self-checking bench for dram_contention_arbiter: expected grants are queued
// as stimulus is applied and compared when the memory port accepts them.
module tb_dram_contention_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int ADDR_W   = 32;
  localparam int TOKEN_W  = 8;
  localparam int REFILL_W = 16;

  logic                      clk;
  logic                      reset;
  logic                      cfg_enable;
  logic [TOKEN_W-1:0]        cfg_tokens_max;
  logic [REFILL_W-1:0]       cfg_refill_period;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      mem_valid;
  logic [ADDR_W-1:0]         mem_addr;
  logic [1:0]                mem_src;
  logic                      mem_ready;
  logic                      busy;
  logic [31:0]               throttle_cycles;

  typedef struct packed {
    logic [1:0]  src;
    logic [31:0] addr;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] addr_tbl [NUM_REQ];
  int          checks_total = 0;
  int          checks_passed = 0;
  int          gnt_count = 0;
  int          g0;
  longint      exp_throttle;

  dram_contention_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .TOKEN_W(TOKEN_W), .REFILL_W(REFILL_W)
  ) dut (
    .clk(clk), .reset(reset), .cfg_enable(cfg_enable), .cfg_tokens_max(cfg_tokens_max),
    .cfg_refill_period(cfg_refill_period), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_src(mem_src),
    .mem_ready(mem_ready), .busy(busy), .throttle_cycles(throttle_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    req_addr = {(NUM_REQ*ADDR_W){1'b0}};
    for (int i = 0; i < NUM_REQ; i++) req_addr[i*ADDR_W +: ADDR_W] = addr_tbl[i];
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks_total++;
    if (obs === exp) checks_passed++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int src, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.src  = 2'(src);
      e.addr = addr_tbl[src];
      sb_q.push_back(e);
    end
  endtask

  // Scoreboard: each accepted memory request must match the oldest expected grant.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && mem_valid && mem_ready) begin
      check_eq("sb_has_entry", (sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check_eq("grant_src", mem_src, e.src);
        check_eq("grant_addr", mem_addr, e.addr);
      end
      gnt_count++;
    end
  end

  initial begin
    reset = 1'b1; cfg_enable = 1'b0; cfg_tokens_max = 8'd0; cfg_refill_period = 16'd0;
    req_valid = 4'hF; mem_ready = 1'b1; exp_throttle = 0;
    for (int i = 0; i < NUM_REQ; i++) addr_tbl[i] = 32'hA000_0000 + 32'(i) * 32'h100;
    tick(3);
    check_eq("rst_mem_valid", mem_valid, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_mem_src", mem_src, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_req_ready", req_ready, 0);
    check_eq("rst_throttle", throttle_cycles, 0);
    reset = 1'b0; req_valid = 4'h0;
    tick(1);

    // Plain round-robin: grants 1,2,3,0,1, one every two cycles
    push_exp(1, 1); push_exp(2, 1); push_exp(3, 1); push_exp(0, 1); push_exp(1, 1);
    g0 = gnt_count;
    req_valid = 4'hF;
    #1 check_eq("rr_first_ready", req_ready, 4'b0010);
    for (int k = 0; k < 10; k++) begin
      tick(1);
      check_eq("rr_mem_valid_cadence", mem_valid, (k % 2 == 0));
    end
    req_valid = 4'h0;
    check_eq("rr_grants", gnt_count - g0, 5);
    check_eq("rr_throttle", throttle_cycles, exp_throttle);

    // Bucket exhaustion on requester 2, refill 1000 cycles after enable
    cfg_tokens_max = 8'd2; cfg_refill_period = 16'd1000; cfg_enable = 1'b1;
    tick(1);
    req_valid = 4'b0100; push_exp(2, 3); g0 = gnt_count;
    tick(4);
    check_eq("bx_two_grants", gnt_count - g0, 2);
    check_eq("bx_throttle0", throttle_cycles, exp_throttle);
    tick(100); exp_throttle += 100;
    check_eq("bx_throttle100", throttle_cycles, exp_throttle);
    check_eq("bx_ready_low", req_ready, 0);
    tick(896); exp_throttle += 896;
    check_eq("bx_throttle_refill", throttle_cycles, exp_throttle);
    check_eq("bx_ready_after_refill", req_ready, 4'b0100);
    check_eq("bx_grants_before_refill", gnt_count - g0, 2);
    tick(1);
    check_eq("bx_refill_valid", mem_valid, 1);
    check_eq("bx_refill_src", mem_src, 2);
    req_valid = 4'h0;
    tick(1);
    check_eq("bx_idle", mem_valid, 0);
    check_eq("bx_grants", gnt_count - g0, 3);
    check_eq("bx_throttle_end", throttle_cycles, exp_throttle);
    cfg_enable = 1'b0;

    // Backpressure: requester 1 held for six cycles
    addr_tbl[1] = 32'hDEAD_0040; push_exp(1, 1);
    mem_ready = 1'b0; req_valid = 4'b0010;
    #1 check_eq("bp_ready", req_ready, 4'b0010);
    tick(1);
    req_valid = 4'h0;
    for (int k = 0; k < 6; k++) begin
      check_eq("bp_valid", mem_valid, 1);
      check_eq("bp_addr", mem_addr, 32'hDEAD_0040);
      check_eq("bp_src", mem_src, 1);
      check_eq("bp_ready_low", req_ready, 0);
      check_eq("bp_busy", busy, 1);
      if (k == 5) mem_ready = 1'b1;
      tick(1);
    end
    check_eq("bp_release_valid", mem_valid, 0);
    check_eq("bp_release_busy", busy, 0);

    // Refill every cycle with consume: continuous grants, bucket capped at 3
    cfg_tokens_max = 8'd3; cfg_refill_period = 16'd1; cfg_enable = 1'b1;
    tick(1);
    req_valid = 4'b0001; push_exp(0, 8); g0 = gnt_count;
    for (int k = 0; k < 16; k++) begin
      tick(1);
      check_eq("sat_cadence", mem_valid, (k % 2 == 0));
    end
    req_valid = 4'h0;
    check_eq("sat_grants", gnt_count - g0, 8);
    check_eq("sat_throttle", throttle_cycles, exp_throttle);
    tick(20);
    cfg_refill_period = 16'd1000;
    req_valid = 4'b0001; push_exp(0, 3); g0 = gnt_count;
    tick(12); exp_throttle += 6;
    check_eq("sat_capped_grants", gnt_count - g0, 3);
    check_eq("sat_capped_throttle", throttle_cycles, exp_throttle);
    req_valid = 4'h0;

    // Enable-edge reload on requester 3
    req_valid = 4'b1000; push_exp(3, 3); g0 = gnt_count;
    tick(8); exp_throttle += 2;
    check_eq("en_drain_grants", gnt_count - g0, 3);
    check_eq("en_drain_throttle", throttle_cycles, exp_throttle);
    req_valid = 4'h0; cfg_enable = 1'b0;
    tick(10);
    check_eq("en_off_throttle", throttle_cycles, exp_throttle);
    cfg_tokens_max = 8'd5; cfg_enable = 1'b1;
    tick(1);
    req_valid = 4'b1000; push_exp(3, 5); g0 = gnt_count;
    tick(10);
    check_eq("en_reload_grants", gnt_count - g0, 5);
    check_eq("en_reload_no_throttle", throttle_cycles, exp_throttle);
    tick(1); exp_throttle += 1;
    check_eq("en_first_throttle", throttle_cycles, exp_throttle);
    req_valid = 4'h0;
    tick(1);

    // Reset while holding a request
    mem_ready = 1'b0; req_valid = 4'b0010;
    tick(1);
    check_eq("rh_valid", mem_valid, 1);
    check_eq("rh_src", mem_src, 1);
    tick(1);
    reset = 1'b1; req_valid = 4'h0;
    tick(1);
    exp_throttle = 0;
    check_eq("rh_mem_valid", mem_valid, 0);
    check_eq("rh_busy", busy, 0);
    check_eq("rh_throttle", throttle_cycles, exp_throttle);
    check_eq("rh_mem_src", mem_src, 0);
    check_eq("rh_mem_addr", mem_addr, 0);
    reset = 1'b0; mem_ready = 1'b1;
    tick(1);
    req_valid = 4'b1001; g0 = gnt_count;
    for (int k = 0; k < 5; k++) begin
      push_exp(3, 1); push_exp(0, 1);
    end
    tick(20);
    check_eq("rh_reload_grants", gnt_count - g0, 10);
    check_eq("rh_reload_throttle", throttle_cycles, exp_throttle);
    tick(1); exp_throttle += 1;
    check_eq("rh_post_throttle", throttle_cycles, exp_throttle);
    req_valid = 4'h0;
    tick(2);
    check_eq("sb_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
